jk_excitation_driver: RTL and testbench
=======================================

# jk_excitation_driver

Drives a bank of WIDTH JK flip-flops to a requested target word. This is the inverse of the JK flip-flop: the flip-flop maps (J, K, q) to the next q, and this block maps (q, target) to J/K excitation. It accepts target words over a valid/ready handshake, drives one excitation cycle, and then checks the fed-back q against the target. It sits between a stimulus or control source and a jk_ff bank, whose q outputs return on q_fb.

## Interface
- WIDTH, 4, number of JK flip-flops driven
- USE_TOGGLE, 0, 1: transitions are driven with J=K=1 (toggle); 0: transitions use pure set (J=1,K=0) or reset (J=0,K=1)
- CNT_W, 8, width of the saturating mismatch counter
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  target word valid
- in_ready  output  1  block can accept a target word (high only in IDLE)
- in_target  input  WIDTH  requested next state of the flip-flop bank
- q_fb  input  WIDTH  current q of the driven jk_ff bank
- j  output  WIDTH  J excitation to the bank (registered)
- k  output  WIDTH  K excitation to the bank (registered)
- done  output  1  one-cycle pulse when a word's check completes
- mismatch  output  1  one-cycle pulse, coincident with done, when q_fb != target
- err_cnt  output  CNT_W  saturating count of mismatches since reset

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- **IDLE**
  - in_ready=1, j=k=0, so the bank holds its value.
  - On in_valid: capture in_target into tgt_q, load j/k from the encoding of (q_fb, in_target) sampled at that edge, then go to DRIVE.
- **DRIVE**
  - in_ready=0; j/k hold the loaded excitation for exactly one cycle.
  - The bank samples j/k at the end of this cycle.
  - At the end of the cycle: j=k=0, go to CHECK.
- **CHECK**
  - in_ready=0, j=k=0.
  - Compare q_fb with tgt_q.
  - Register done=1 for one cycle. Register mismatch=1 if any bit differs.
  - On a mismatch, err_cnt increments, saturating at all-ones.
  - Return to IDLE.
- Per-bit encoding, written (q, t) -> (J, K):
  - (0,0) -> (0,0)
  - (1,1) -> (0,0)
  - (0,1) -> (1, USE_TOGGLE)
  - (1,0) -> (USE_TOGGLE, 1)
- J=K=1 is never emitted for a bit whose q already equals its target.
- in_valid while in_ready=0 is ignored, and the word is not captured. The source must hold in_valid and in_target until it sees in_ready high.
- done and mismatch are registered outputs, asserted during the cycle after the CHECK edge.

## Timing
- Reset values: in_ready=1 (IDLE), j=0, k=0, done=0, mismatch=0, err_cnt=0, tgt_q=0.
- Accept edge E0 (IDLE, in_valid=1) leads to:
  - j/k valid during E0..E1;
  - the bank updates at E1;
  - q_fb is compared at E2;
  - done/mismatch are high during E2..E3;
  - in_ready is high again from E2.
- Throughput: one word per 3 cycles. Back-to-back is allowed: a new word may be accepted at E3 while done is high.
- Identity target (in_target == q_fb): j=k=0 in DRIVE, and done still pulses after the normal latency.
- err_cnt at all-ones stays at all-ones on further mismatches. done still pulses.
- Asynchronous rst mid-operation (DRIVE or CHECK):
  - immediately forces IDLE and j=k=0;
  - clears done, mismatch and err_cnt;
  - the in-flight word is dropped with no done pulse.
- Operation resumes on the first clk edge after rst deasserts.

## Test plan
- **Reset:** assert rst with random inputs. Required: in_ready=1, j=k=0, done=0, err_cnt=0; the values hold while rst=1.
- **Set/reset, USE_TOGGLE=0:** q_fb=4'b0011, target 4'b0101.
  - During DRIVE: j=4'b0100, k=4'b0010.
  - Bank q becomes 0101, then done=1 and mismatch=0.
- **Toggle encoding, USE_TOGGLE=1:** same stimulus.
  - During DRIVE: j=4'b0110, k=4'b0110.
  - Bank q becomes 0101, then done=1 and mismatch=0.
- **Handshake:**
  - Hold in_valid across 3 words (0001, 1111, 0000). Required: in_ready is low for 2 cycles after each accept, there are exactly 3 done pulses, and the final q is 0000.
  - in_valid asserted during DRIVE alone, then dropped before the next IDLE cycle, is not captured.
- **Mismatch:** force q_fb stuck at 0000 with target 1010. Required: mismatch=1 and err_cnt=1. Repeating this 300 times with CNT_W=8 leaves err_cnt=255.
- **Reset mid-operation:** pulse rst during DRIVE. Required: j=k=0 immediately, no done pulse, in_ready=1, and the next word is accepted normally.

Source files
------------

// File: rtl/jk_excitation_driver_if.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver_if
//
// Bundles the target-word handshake, the J/K excitation bus towards a bank
// of JK flip-flops, the fed-back q of that bank and the check results.
//
// Signals:
//   in_valid  - target word valid (environment -> driver)
//   in_ready  - driver can accept a target word (driver -> environment)
//   in_target - requested next state of the flip-flop bank
//   q_fb      - current q of the driven JK bank (bank -> driver)
//   j, k      - registered J/K excitation (driver -> bank)
//   done      - one-cycle pulse when a word's check completes
//   mismatch  - one-cycle pulse with done when the bank missed the target
//   err_cnt   - saturating count of mismatches since reset
//
// Modports:
//   master - the environment side (stimulus source plus the bank's q)
//   slave  - the excitation driver itself
// ---------------------------------------------------------------------------
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_target;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             done;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid,
        output in_target,
        output q_fb,
        input  in_ready,
        input  j,
        input  k,
        input  done,
        input  mismatch,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  in_target,
        input  q_fb,
        output in_ready,
        output j,
        output k,
        output done,
        output mismatch,
        output err_cnt
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
//
// Drives a bank of WIDTH JK flip-flops to a requested target word. It is the
// inverse of a JK flip-flop: from the bank's current q and the wanted next
// state it derives the J/K excitation, applies it for exactly one cycle and
// then checks that the bank really reached the target.
//
// Flow per word (three cycles, back-to-back allowed):
//   IDLE  : in_ready=1, j=k=0. On in_valid the target is captured and the
//           excitation for (q_fb, in_target) is registered onto j/k.
//   DRIVE : j/k present the excitation; the bank samples it at the end of
//           this cycle. j/k return to zero on the following edge.
//   CHECK : q_fb is compared with the captured target; done (and mismatch
//           when any bit differs) is registered for one cycle and the
//           mismatch counter advances, saturating at all-ones.
//
// Parameters:
//   WIDTH      - number of JK flip-flops driven
//   USE_TOGGLE - nonzero: bits that must change use J=K=1 (toggle);
//                zero: they use pure set (J=1,K=0) or reset (J=0,K=1)
//   CNT_W      - width of the saturating mismatch counter
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (forces IDLE, clears all outputs,
//         drops any in-flight word without a done pulse)
//   bus - slave side of jk_excitation_driver_if
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
    parameter int WIDTH      = 4,
    parameter int USE_TOGGLE = 0,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    jk_excitation_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // All-ones when toggling is enabled: adds the "other" excitation input on
    // changing bits so that a changing bit gets J=K=1 instead of set/reset.
    localparam logic [WIDTH-1:0] TOG_MASK = (USE_TOGGLE != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONES_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1'b1);

    // J excitation: a 0->1 bit always needs J=1; a 1->0 bit needs J=1 only
    // when toggling. Stable bits get J=0, so J=K=1 never hits a stable bit.
    function automatic logic [WIDTH-1:0] enc_j(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] t);
        return (~q & t) | (TOG_MASK & q & ~t);
    endfunction

    // K excitation: a 1->0 bit always needs K=1; a 0->1 bit needs K=1 only
    // when toggling.
    function automatic logic [WIDTH-1:0] enc_k(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] t);
        return (q & ~t) | (TOG_MASK & ~q & t);
    endfunction

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == ONES_C) begin
            r = c;
        end else begin
            r = c + ONE_C;
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] tgt_s;
    logic [WIDTH-1:0] j_r;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_r;
    logic [WIDTH-1:0] k_s;
    logic             ready_r;
    logic             ready_s;
    logic             done_r;
    logic             done_s;
    logic             mism_r;
    logic             mism_s;
    logic [CNT_W-1:0] err_r;
    logic [CNT_W-1:0] err_s;

    // Next-state and next-output decode; every output is registered, so this
    // block computes the values that appear after the coming edge.
    always_comb begin
        state_s = state_r;
        tgt_s   = tgt_r;
        j_s     = ZERO_W;
        k_s     = ZERO_W;
        done_s  = 1'b0;
        mism_s  = 1'b0;
        err_s   = err_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Encode against q_fb as seen at the accept edge; the bank
                    // cannot move in IDLE because j=k=0 there.
                    tgt_s   = bus.in_target;
                    j_s     = enc_j(bus.q_fb, bus.in_target);
                    k_s     = enc_k(bus.q_fb, bus.in_target);
                    state_s = ST_DRIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // Excitation is held for this single cycle only; j/k fall
                // back to zero (the defaults) on the next edge.
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                // The bank updated at the end of DRIVE, so q_fb now shows the
                // result of the excitation.
                done_s = 1'b1;
                mism_s = |(bus.q_fb ^ tgt_r);
                if (mism_s) begin
                    err_s = sat_inc(err_r);
                end else begin
                    err_s = err_r;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; asynchronous reset returns to IDLE with the
    // bank held (j=k=0) and all status cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tgt_r   <= ZERO_W;
            j_r     <= ZERO_W;
            k_r     <= ZERO_W;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            mism_r  <= 1'b0;
            err_r   <= ZERO_C;
        end else begin
            state_r <= state_s;
            tgt_r   <= tgt_s;
            j_r     <= j_s;
            k_r     <= k_s;
            ready_r <= ready_s;
            done_r  <= done_s;
            mism_r  <= mism_s;
            err_r   <= err_s;
        end
    end

    assign bus.in_ready = ready_r;
    assign bus.j        = j_r;
    assign bus.k        = k_r;
    assign bus.done     = done_r;
    assign bus.mismatch = mism_r;
    assign bus.err_cnt  = err_r;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_excitation_driver
//
// Two driver instances (set/reset encoding and toggle encoding) receive the
// same target stream. Each drives its own behavioural JK bank whose q feeds
// back on q_fb; the bank can be preloaded or replaced by a stuck value.
// ---------------------------------------------------------------------------
module tb_jk_excitation_driver;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    typedef struct {
        logic [3:0] q0;
        logic [3:0] tgt;
        logic [3:0] j0;
        logic [3:0] k0;
        logic [3:0] j1;
        logic [3:0] k1;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_target;
    logic       bank_load;
    logic [3:0] load_val;
    logic       stuck;
    logic [3:0] stuck_val;
    logic [3:0] bank0;
    logic [3:0] bank1;

    int n_cmp;
    int n_fail;

    vec_t vecs[6];

    jk_excitation_driver_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if0 ();
    jk_excitation_driver_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if1 ();

    jk_excitation_driver #(.WIDTH(WIDTH), .USE_TOGGLE(0), .CNT_W(CNT_W)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    jk_excitation_driver #(.WIDTH(WIDTH), .USE_TOGGLE(1), .CNT_W(CNT_W)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    assign if0.in_valid  = in_valid;
    assign if1.in_valid  = in_valid;
    assign if0.in_target = in_target;
    assign if1.in_target = in_target;
    assign if0.q_fb      = stuck ? stuck_val : bank0;
    assign if1.q_fb      = stuck ? stuck_val : bank1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural JK bank: q+ = J&~q | ~K&q, with a preload path.
    always @(posedge clk) begin
        if (bank_load) begin
            bank0 <= load_val;
            bank1 <= load_val;
        end else begin
            bank0 <= (if0.j & ~bank0) | (~if0.k & bank0);
            bank1 <= (if1.j & ~bank1) | (~if1.k & bank1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [3:0] v);
        bank_load = 1'b1;
        load_val  = v;
        tick();
        bank_load = 1'b0;
    endtask

    // One full word on both drivers; entered and left just after a rising edge
    // with both drivers in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        load_bank(v.q0);
        in_valid  = 1'b1;
        in_target = v.tgt;
        @(negedge clk);
        chk({tag, ".ready_idle0"}, 32'(if0.in_ready), 32'd1);
        chk({tag, ".ready_idle1"}, 32'(if1.in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".j0"}, 32'(if0.j), 32'(v.j0));
        chk({tag, ".k0"}, 32'(if0.k), 32'(v.k0));
        chk({tag, ".j1"}, 32'(if1.j), 32'(v.j1));
        chk({tag, ".k1"}, 32'(if1.k), 32'(v.k1));
        chk({tag, ".ready_drive"}, 32'(if0.in_ready), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, ".j_check"}, 32'({if0.j, if0.k, if1.j, if1.k}), 32'd0);
        chk({tag, ".done_early"}, 32'({if0.done, if1.done}), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, ".done"}, 32'({if0.done, if1.done}), 32'h3);
        chk({tag, ".mismatch"}, 32'({if0.mismatch, if1.mismatch}), 32'h0);
        chk({tag, ".bank0"}, 32'(bank0), 32'(v.tgt));
        chk({tag, ".bank1"}, 32'(bank1), 32'(v.tgt));
        chk({tag, ".ready_back"}, 32'({if0.in_ready, if1.in_ready}), 32'h3);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        logic [3:0]  words[3];
        logic        exp_rdy[12];
        int          wi;
        int          d0;
        int          d1;
        logic        acc;

        // Hand-computed (q, target) -> excitation for both encodings.
        vecs[0] = '{q0: 4'b0011, tgt: 4'b0101, j0: 4'b0100, k0: 4'b0010, j1: 4'b0110, k1: 4'b0110};
        vecs[1] = '{q0: 4'b0000, tgt: 4'b1111, j0: 4'b1111, k0: 4'b0000, j1: 4'b1111, k1: 4'b1111};
        vecs[2] = '{q0: 4'b1111, tgt: 4'b0000, j0: 4'b0000, k0: 4'b1111, j1: 4'b1111, k1: 4'b1111};
        vecs[3] = '{q0: 4'b1010, tgt: 4'b1010, j0: 4'b0000, k0: 4'b0000, j1: 4'b0000, k1: 4'b0000};
        vecs[4] = '{q0: 4'b1100, tgt: 4'b1010, j0: 4'b0010, k0: 4'b0100, j1: 4'b0110, k1: 4'b0110};
        vecs[5] = '{q0: 4'b0110, tgt: 4'b1001, j0: 4'b1001, k0: 4'b0110, j1: 4'b1111, k1: 4'b1111};

        words[0] = 4'b0001;
        words[1] = 4'b1111;
        words[2] = 4'b0000;
        exp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_target = 4'b0000;
        bank_load = 1'b1;
        load_val  = 4'b0000;
        stuck     = 1'b1;
        stuck_val = 4'b0000;

        // Reset with random inputs: outputs stay at their reset values.
        for (int c = 0; c < 5; c++) begin
            rnd       = $urandom;
            in_valid  = rnd[0];
            in_target = rnd[7:4];
            stuck_val = rnd[11:8];
            @(negedge clk);
            chk("rst.ready", 32'({if0.in_ready, if1.in_ready}), 32'h3);
            chk("rst.jk", 32'({if0.j, if0.k, if1.j, if1.k}), 32'd0);
            chk("rst.done", 32'({if0.done, if1.done, if0.mismatch, if1.mismatch}), 32'd0);
            chk("rst.err", 32'({if0.err_cnt, if1.err_cnt}), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        stuck     = 1'b0;
        bank_load = 1'b0;
        rst       = 1'b0;
        tick();

        // Table-driven words on both encodings.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Held in_valid across three words: back-to-back acceptance.
        load_bank(4'b0101);
        in_valid  = 1'b1;
        in_target = words[0];
        wi = 0;
        d0 = 0;
        d1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("hs.ready0[%0d]", c), 32'(if0.in_ready), 32'(exp_rdy[c]));
            chk($sformatf("hs.ready1[%0d]", c), 32'(if1.in_ready), 32'(exp_rdy[c]));
            if (if0.done) d0++;
            if (if1.done) d1++;
            acc = if0.in_ready & in_valid;
            tick();
            if (acc) begin
                wi++;
                if (wi < 3) begin
                    in_target = words[wi];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("hs.accepts", 32'(wi), 32'd3);
        chk("hs.done0", 32'(d0), 32'd3);
        chk("hs.done1", 32'(d1), 32'd3);
        chk("hs.bank", 32'({bank0, bank1}), 32'h00);

        // in_valid only during DRIVE is ignored.
        load_bank(4'b0000);
        in_valid  = 1'b1;
        in_target = 4'b0110;
        tick();
        in_target = 4'b1001;
        tick();
        in_valid = 1'b0;
        d0 = 0;
        d1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if0.done) d0++;
            if (if1.done) d1++;
            tick();
        end
        chk("drop.done0", 32'(d0), 32'd1);
        chk("drop.done1", 32'(d1), 32'd1);
        chk("drop.bank", 32'({bank0, bank1}), 32'h66);
        chk("drop.ready", 32'({if0.in_ready, if1.in_ready}), 32'h3);

        // Stuck bank: every word mismatches; counter saturates at 255.
        stuck     = 1'b1;
        stuck_val = 4'b0000;
        for (int n = 1; n <= 300; n++) begin
            in_valid  = 1'b1;
            in_target = 4'b1010;
            tick();
            in_valid = 1'b0;
            if (n == 1) begin
                @(negedge clk);
                chk("mm.j0", 32'(if0.j), 32'h0000_000a);
            end
            tick();
            tick();
            @(negedge clk);
            if (n == 1) begin
                chk("mm.first", 32'({if0.done, if0.mismatch, if1.done, if1.mismatch}), 32'hf);
                chk("mm.err1", 32'({if0.err_cnt, if1.err_cnt}), 32'h0101);
            end
            if (n == 254) begin
                chk("mm.err254", 32'(if0.err_cnt), 32'd254);
            end
            if (n == 255) begin
                chk("mm.err255", 32'({if0.err_cnt, if1.err_cnt}), 32'hffff);
            end
            if (n == 300) begin
                chk("mm.sat", 32'({if0.err_cnt, if1.err_cnt}), 32'hffff);
                chk("mm.sat_pulse", 32'({if0.done, if0.mismatch, if1.done, if1.mismatch}), 32'hf);
            end
            tick();
        end
        stuck = 1'b0;

        // Reset during DRIVE drops the word.
        load_bank(4'b0011);
        in_valid  = 1'b1;
        in_target = 4'b0101;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid.jdrive", 32'(if0.j), 32'h4);
        #1;
        rst = 1'b1;
        #1;
        chk("mid.jk", 32'({if0.j, if0.k, if1.j, if1.k}), 32'd0);
        chk("mid.ready", 32'({if0.in_ready, if1.in_ready}), 32'h3);
        chk("mid.err", 32'({if0.err_cnt, if1.err_cnt}), 32'd0);
        tick();
        rst = 1'b0;
        d0 = 0;
        d1 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (if0.done) d0++;
            if (if1.done) d1++;
            tick();
        end
        chk("mid.nodone", 32'(d0 + d1), 32'd0);
        chk("mid.bank", 32'({bank0, bank1}), 32'h33);
        chk("mid.ready_after", 32'({if0.in_ready, if1.in_ready}), 32'h3);
        run_vec(vecs[0], "post_rst");
        chk("post_rst.err", 32'({if0.err_cnt, if1.err_cnt}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
